// File: rtl/unary_acc_pkg.sv
// Shared types and constants for the unary-to-binary partial-sum accumulator.
`timescale 1ns/1ps
package unary_acc_pkg;

  localparam int LEN_WIDTH  = 16;
  localparam int PSUM_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  typedef logic [LEN_WIDTH-1:0] len_t;

  // Bit patterns of the signed extremes; callers truncate to their own width.
  function automatic logic [63:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] acc_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

  localparam logic [PSUM_WIDTH-1:0] ACC_MAX = PSUM_WIDTH'(acc_max(PSUM_WIDTH));
  localparam logic [PSUM_WIDTH-1:0] ACC_MIN = PSUM_WIDTH'(acc_min(PSUM_WIDTH));

endpackage

// File: rtl/unary_acc_sat_step.sv
// Combinational signed +1/-1 step that clamps at the two's-complement extremes.
`timescale 1ns/1ps
module sat_step
  import unary_acc_pkg::*;
#(
  parameter int ACC_WIDTH = PSUM_WIDTH
) (
  input  logic [ACC_WIDTH-1:0] acc,
  input  logic                 up,
  input  logic                 dn,
  output logic [ACC_WIDTH-1:0] next,
  output logic                 sat
);

  localparam logic [ACC_WIDTH-1:0] MAX = ACC_WIDTH'(acc_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] MIN = ACC_WIDTH'(acc_min(ACC_WIDTH));

  // Opposing requests cancel; a step past either extreme holds and flags.
  always_comb begin
    next = acc;
    sat  = 1'b0;
    if (up && !dn) begin
      if (acc == MAX) sat = 1'b1;
      else            next = acc + ACC_WIDTH'(1);
    end else if (dn && !up) begin
      if (acc == MIN) sat = 1'b1;
      else            next = acc - ACC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/unary_acc.sv
// Accumulates a signed unary product stream over a programmed window onto an
// incoming partial sum and hands the result downstream over valid/ready.
`timescale 1ns/1ps
module unary_acc
  import unary_acc_pkg::*;
#(
  parameter int WIDTH     = LEN_WIDTH,
  parameter int ACC_WIDTH = PSUM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_len,
  input  logic [ACC_WIDTH-1:0] i_psum,
  input  logic                 i_sign,
  input  logic                 i_en,
  input  logic                 i_bit,
  input  logic                 i_clear,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [ACC_WIDTH-1:0] o_psum,
  output logic                 o_sat,
  output logic                 o_busy
);

  state_t               state;
  state_t               state_nx;
  logic [WIDTH-1:0]     cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic                 sign;
  logic                 sat_flag;
  logic                 accept;
  logic                 step_en;
  logic [ACC_WIDTH-1:0] step_next;
  logic                 step_sat;

  // A new window may load from IDLE, or from HOLD in the handshake cycle.
  assign accept  = i_start && (i_len != '0) && !i_clear &&
                   ((state == IDLE) || ((state == HOLD) && i_ready));
  assign step_en = (state == RUN) && i_en && !i_clear;

  sat_step #(
    .ACC_WIDTH(ACC_WIDTH)
  ) u_step (
    .acc  (acc),
    .up   (step_en && i_bit && !sign),
    .dn   (step_en && i_bit && sign),
    .next (step_next),
    .sat  (step_sat)
  );

  always_comb begin
    state_nx = state;
    if (i_clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nx = RUN;
        RUN:  if (i_en && (cnt == WIDTH'(1))) state_nx = HOLD;
        HOLD: if (i_ready) state_nx = accept ? RUN : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      sat_flag <= 1'b0;
    end else if (accept) begin
      acc      <= i_psum;
      cnt      <= i_len;
      sign     <= i_sign;
      sat_flag <= 1'b0;
    end else if (step_en) begin
      acc <= step_next;
      if (step_sat)          sat_flag <= 1'b1;
      if (cnt != WIDTH'(1))  cnt <= cnt - WIDTH'(1);
    end
  end

  assign o_valid = (state == HOLD);
  assign o_busy  = (state != IDLE);
  assign o_psum  = acc;
  assign o_sat   = sat_flag;

endmodule

// File: tb/tb_unary_acc.sv
// Directed scoreboard bench for unary_acc: stimulus queues expected results,
// a negedge monitor compares them whenever the DUT presents o_valid.
`timescale 1ns/1ps
module tb_unary_acc;
  import unary_acc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_sign, i_en, i_bit, i_clear, i_ready;
  len_t        i_len;
  logic [31:0] i_psum;
  logic        o_valid, o_sat, o_busy;
  logic [31:0] o_psum;

  typedef struct packed {
    logic [31:0] psum;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  unary_acc dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (i_start),
    .i_len   (i_len),
    .i_psum  (i_psum),
    .i_sign  (i_sign),
    .i_en    (i_en),
    .i_bit   (i_bit),
    .i_clear (i_clear),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_psum  (o_psum),
    .o_sat   (o_sat),
    .o_busy  (o_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare every presented result against the head of the queue; pop on handshake.
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_valid: got o_valid=1 o_psum=%h expected no result", o_psum);
      end else begin
        checkOutput("scoreboard_psum", o_psum, exp_q[0].psum);
        checkOutput("scoreboard_sat", {31'd0, o_sat}, {31'd0, exp_q[0].sat});
        if (i_ready && !i_clear) void'(exp_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input len_t len, input logic [31:0] psum, input logic sign,
                               input logic [31:0] bits, input int stall_at,
                               input int stall_cycles, input int ready_delay,
                               input bit do_handshake, input logic [31:0] exp_psum,
                               input logic exp_sat);
    exp_q.push_back('{psum: exp_psum, sat: exp_sat});
    i_start = 1'b1;
    i_len   = len;
    i_psum  = psum;
    i_sign  = sign;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < int'(len); k++) begin
      if (k == stall_at) begin
        i_en  = 1'b0;
        i_bit = 1'b1;
        repeat (stall_cycles) tick();
      end
      i_en  = 1'b1;
      i_bit = bits[k];
      if (k == int'(len) - 1) checkOutput("valid_not_early", {31'd0, o_valid}, 32'd0);
      tick();
    end
    i_en  = 1'b0;
    i_bit = 1'b0;
    checkOutput("valid_on_time", {31'd0, o_valid}, 32'd1);
    repeat (ready_delay) tick();
    if (do_handshake) begin
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_len   = '0;
    i_psum  = '0;
    i_sign  = 1'b0;
    i_en    = 1'b0;
    i_bit   = 1'b0;
    i_clear = 1'b0;
    i_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
    checkOutput("reset_psum", o_psum, 32'd0);
    checkOutput("reset_sat", {31'd0, o_sat}, 32'd0);
    checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic add");
    applyStimulus(16'd8, 32'd100, 1'b0, 32'h0000_00ED, -1, 0, 0, 1'b1, 32'd106, 1'b0);
    checkOutput("idle_after_handshake", {31'd0, o_busy}, 32'd0);

    $display("[TB] negative product");
    applyStimulus(16'd4, 32'd3, 1'b1, 32'h0000_000F, -1, 0, 1, 1'b1, 32'hFFFF_FFFF, 1'b0);

    $display("[TB] positive saturation");
    applyStimulus(16'd4, 32'h7FFF_FFFE, 1'b0, 32'h0000_000F, -1, 0, 0, 1'b1, 32'h7FFF_FFFF, 1'b1);

    $display("[TB] negative saturation");
    applyStimulus(16'd4, 32'h8000_0001, 1'b1, 32'h0000_000F, -1, 0, 0, 1'b1, 32'h8000_0000, 1'b1);

    $display("[TB] stall, back-pressure and chained start");
    applyStimulus(16'd6, 32'd1000, 1'b0, 32'h0000_003F, 3, 3, 5, 1'b0, 32'd1006, 1'b0);
    exp_q.push_back('{psum: 32'd48, sat: 1'b0});
    i_ready = 1'b1;
    i_start = 1'b1;
    i_len   = 16'd2;
    i_psum  = 32'd50;
    i_sign  = 1'b1;
    tick();
    i_start = 1'b0;
    i_ready = 1'b0;
    checkOutput("chain_busy", {31'd0, o_busy}, 32'd1);
    checkOutput("chain_no_bubble", {31'd0, o_valid}, 32'd0);
    i_en  = 1'b1;
    i_bit = 1'b1;
    tick();
    tick();
    i_en  = 1'b0;
    i_bit = 1'b0;
    checkOutput("chain_valid", {31'd0, o_valid}, 32'd1);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;

    $display("[TB] clear mid-window");
    i_start = 1'b1;
    i_len   = 16'd8;
    i_psum  = 32'd77;
    i_sign  = 1'b0;
    tick();
    i_start = 1'b0;
    i_en    = 1'b1;
    i_bit   = 1'b1;
    repeat (3) tick();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    checkOutput("clear_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("clear_keeps_acc", o_psum, 32'd80);
    for (int c = 0; c < 10; c++) begin
      checkOutput("clear_no_valid", {31'd0, o_valid}, 32'd0);
      tick();
    end
    i_en  = 1'b0;
    i_bit = 1'b0;

    $display("[TB] zero-length start");
    i_start = 1'b1;
    i_len   = 16'd0;
    i_psum  = 32'd999;
    tick();
    i_start = 1'b0;
    checkOutput("len0_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("len0_no_load", o_psum, 32'd80);
    tick();
    checkOutput("len0_still_idle", {31'd0, o_busy}, 32'd0);

    $display("[TB] asynchronous reset mid-window");
    i_start = 1'b1;
    i_len   = 16'd8;
    i_psum  = 32'h7FFF_FFFF;
    i_sign  = 1'b0;
    tick();
    i_start = 1'b0;
    i_en    = 1'b1;
    i_bit   = 1'b1;
    tick();
    tick();
    checkOutput("sat_in_window", {31'd0, o_sat}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_psum", o_psum, 32'd0);
    checkOutput("async_reset_sat", {31'd0, o_sat}, 32'd0);
    checkOutput("async_reset_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("async_reset_valid", {31'd0, o_valid}, 32'd0);
    i_en  = 1'b0;
    i_bit = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_idle", {31'd0, o_busy}, 32'd0);

    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/unary_acc.md
Name: unary_acc

Overview:
- Downstream consumer of the unary-rate multiplier PE bitstream (product bit o_bit).
- Accumulates that bitstream over a programmable window of cycles, signed by the product sign.
- Adds the result onto an incoming binary partial sum and presents it to the next stage of the systolic column over a valid/ready handshake.
- One instance per PE output; converts unary products back into binary partial sums.

Parameters:
- WIDTH, 16, operand width; window length field is WIDTH bits.
- ACC_WIDTH, 32, signed two's-complement partial-sum width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  window start request; accepted only in IDLE, or in HOLD on the same cycle as the output handshake.
- i_len  input  WIDTH  window length in cycles, sampled on accept; 0 means the start is ignored.
- i_psum  input  ACC_WIDTH  signed partial sum, loaded into the accumulator on accept.
- i_sign  input  1  product sign, sampled on accept: 0 means +1 per bit, 1 means -1 per bit.
- i_en  input  1  stream enable; low stalls RUN, with no count and no accumulate.
- i_bit  input  1  product bitstream from the PE.
- i_clear  input  1  synchronous abort.
- i_ready  input  1  downstream ready.
- o_valid  output  1  o_psum valid.
- o_psum  output  ACC_WIDTH  accumulator register.
- o_sat  output  1  accumulator saturated during the current or last window; sticky per window.
- o_busy  output  1  high in RUN or HOLD.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; o_valid 0; o_psum 0; o_sat 0; o_busy 0; cycle counter 0; latched sign 0. Assertion of rst_n low mid-window takes effect immediately, with no partial result emitted.
- States: IDLE, RUN, HOLD, 2-bit encoding.
- IDLE:
  - i_start=1 and i_len!=0 (cycle N) → RUN.
  - On that edge: acc<=i_psum, cnt<=i_len, sign<=i_sign, o_sat<=0.
- RUN:
  - Each cycle with i_en=1: acc <= sat(acc ± i_bit), cnt <= cnt-1.
  - When cnt==1 and i_en=1 → HOLD.
  - With no stalls, i_bit is sampled in cycles N+1..N+len, and o_valid=1 from cycle N+len+1.
  - i_en=0: state, cnt and acc all hold.
  - i_start ignored in RUN.
- HOLD:
  - o_valid=1, with o_psum stable until handshake.
  - i_ready=1 → IDLE, unless i_start=1 with i_len!=0 on the same cycle. In that case the new window loads as from IDLE and goes straight to RUN, with no bubble.
  - i_bit and i_en ignored.
- i_clear=1 in any state → IDLE next edge; o_valid 0; acc and o_sat unchanged. i_clear has priority over i_start and the handshake.
- Arithmetic:
  - Signed ACC_WIDTH add of +1 or -1, only when i_bit=1.
  - Saturates at 2^(ACC_WIDTH-1)-1 and -2^(ACC_WIDTH-1); either event sets o_sat, which stays set until the next accept.
  - No wrap-around.
- Counter: WIDTH bits, so the maximum window is 2^WIDTH-1 cycles. Never decrements below 1 in RUN.
- o_busy = (state != IDLE).
- o_psum is driven directly by the acc register, with no combinational path from inputs.

Decomposition:
- unary_acc_pkg holds:
  - the state enum typedef (IDLE/RUN/HOLD);
  - ACC_MAX and ACC_MIN constants, as functions of ACC_WIDTH;
  - the len typedef.
- One sub-module, sat_step: combinational signed ±1 saturating step. Inputs acc, up, dn; outputs next and sat. Instantiated once.
- The FSM and counter stay in unary_acc.

Test Plan:
- Basic add: i_len=8, i_psum=100, i_sign=0, bits 1,0,1,1,0,1,1,1 from N+1 → o_valid at N+9, o_psum=106, o_sat=0.
- Negative product: i_len=4, i_psum=3, i_sign=1, all ones → o_psum=-1 (0xFFFFFFFF).
- Saturation: i_psum=0x7FFFFFFE, i_len=4, i_sign=0, all ones → o_psum=0x7FFFFFFF, o_sat=1.
- Negative saturation: i_psum=0x80000001, i_sign=1, i_len=4, all ones → o_psum=0x80000000, o_sat=1.
- Stall and back-pressure: i_len=6, all ones, i_en low for 3 cycles mid-window → o_valid at N+10, o_psum=i_psum+6. i_ready held low 5 cycles → o_psum stable. Handshake with i_start, i_len=2 → RUN next cycle, new result valid 3 cycles later.
- Abort, reset and illegal start:
  - i_clear mid-RUN → IDLE, o_valid never asserts.
  - rst_n low mid-RUN → all outputs 0 asynchronously.
  - i_start with i_len=0 → stays IDLE, o_busy=0.
